// File: rtl/control_sequencer_if.sv
// Control strobes and status between the sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [2:0]       opcode;
  logic             zero;
  logic             pc_out;
  logic             pc_inc;
  logic             pc_load;
  logic             mar_load;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_load;
  logic             ir_clear;
  logic             ir_out;
  logic             acc_load;
  logic             acc_out;
  logic             b_load;
  logic [1:0]       alu_op;
  logic             flags_load;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, opcode, zero,
    output pc_out, pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load, ir_clear, ir_out,
           acc_load, acc_out, b_load, alu_op, flags_load, halted, instr_count
  );

  modport slave (
    output run, opcode, zero,
    input  pc_out, pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load, ir_clear, ir_out,
           acc_load, acc_out, b_load, alu_op, flags_load, halted, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the accumulator datapath strobes.
module control_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                clear_n,
  control_sequencer_if.master bus
);
  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpLda = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpSub = 3'd3;
  localparam logic [2:0] OpSta = 3'd4;
  localparam logic [2:0] OpJmp = 3'd5;
  localparam logic [2:0] OpJz  = 3'd6;
  localparam logic [2:0] OpHlt = 3'd7;

  localparam logic [1:0] AluPass = 2'b00;
  localparam logic [1:0] AluAdd  = 2'b01;
  localparam logic [1:0] AluSub  = 2'b10;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StF0   = 3'd1,
    StF1   = 3'd2,
    StDec  = 3'd3,
    StE1   = 3'd4,
    StE2   = 3'd5,
    StHalt = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] count_q;
  logic             retire, go_halt;

  logic pc_out, pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load, ir_clear, ir_out;
  logic acc_load, acc_out, b_load, flags_load, halted;
  logic [1:0] alu_op;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    retire     = 1'b0;
    go_halt    = 1'b0;
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_load    = 1'b0;
    ir_clear   = 1'b0;
    ir_out     = 1'b0;
    acc_load   = 1'b0;
    acc_out    = 1'b0;
    b_load     = 1'b0;
    alu_op     = AluPass;
    flags_load = 1'b0;
    halted     = 1'b0;

    case (state_q)
      StIdle: begin
        ir_clear = 1'b1;
        if (bus.run) state_d = StF0;
      end
      StF0: begin
        pc_out   = 1'b1;
        mar_load = 1'b1;
        state_d  = StF1;
      end
      StF1: begin
        mem_rd  = 1'b1;
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = StDec;
      end
      StDec: begin
        // Execute states decode from this latched copy, not the live IR.
        op_d = bus.opcode;
        case (bus.opcode)
          OpNop: retire = 1'b1;
          OpLda, OpAdd, OpSub, OpSta: begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
            state_d  = StE1;
          end
          OpJmp: begin
            ir_out  = 1'b1;
            pc_load = 1'b1;
            retire  = 1'b1;
          end
          OpJz: begin
            ir_out  = 1'b1;
            pc_load = bus.zero;
            retire  = 1'b1;
          end
          default: begin
            retire  = 1'b1;
            go_halt = 1'b1;
          end
        endcase
      end
      StE1: begin
        case (op_q)
          OpLda: begin
            mem_rd     = 1'b1;
            acc_load   = 1'b1;
            alu_op     = AluPass;
            flags_load = 1'b1;
            retire     = 1'b1;
          end
          OpAdd, OpSub: begin
            mem_rd  = 1'b1;
            b_load  = 1'b1;
            state_d = StE2;
          end
          OpSta: begin
            acc_out = 1'b1;
            mem_wr  = 1'b1;
            retire  = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
      StE2: begin
        acc_load   = 1'b1;
        flags_load = 1'b1;
        alu_op     = (op_q == OpSub) ? AluSub : AluAdd;
        retire     = 1'b1;
      end
      StHalt: halted = 1'b1;
      default: state_d = StIdle;
    endcase

    if (retire) begin
      if (go_halt)      state_d = StHalt;
      else if (bus.run) state_d = StF0;
      else              state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.pc_out      = pc_out;
  assign bus.pc_inc      = pc_inc;
  assign bus.pc_load     = pc_load;
  assign bus.mar_load    = mar_load;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_wr      = mem_wr;
  assign bus.ir_load     = ir_load;
  assign bus.ir_clear    = ir_clear;
  assign bus.ir_out      = ir_out;
  assign bus.acc_load    = acc_load;
  assign bus.acc_out     = acc_out;
  assign bus.b_load      = b_load;
  assign bus.alu_op      = alu_op;
  assign bus.flags_load  = flags_load;
  assign bus.halted      = halted;
  assign bus.instr_count = count_q;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit directly downstream of the instruction register.
- Consumes the 3-bit opcode field (instruction bits [7:5]) and the ALU zero flag.
- Drives every datapath strobe: PC, MAR, memory, IR load/clear, ACC, B register, ALU, flags.
- Sequences fetch -> decode -> execute per instruction; counts retired instructions; parks on HLT.

Parameters:
- CNT_W, 16, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock, rising edge.
- clear_n  input  1  asynchronous active-low reset.
- run  input  1  enable; sampled at each instruction boundary.
- opcode  input  3  IR opcode field, valid from the cycle after ir_load.
- zero  input  1  ALU zero flag, registered in the datapath.
- pc_out  output  1  PC drives the address bus.
- pc_inc  output  1  PC increments at next edge.
- pc_load  output  1  PC loads from the operand bus.
- mar_load  output  1  MAR loads from the bus.
- mem_rd  output  1  memory read onto the data bus.
- mem_wr  output  1  memory write from the data bus.
- ir_load  output  1  IR load strobe.
- ir_clear  output  1  IR clear strobe.
- ir_out  output  1  IR operand [3:0] drives the bus.
- acc_load  output  1  ACC loads from the ALU result.
- acc_out  output  1  ACC drives the data bus.
- b_load  output  1  B register loads from the data bus.
- alu_op  output  2  ALU function: 00 PASS, 01 ADD, 10 SUB.
- flags_load  output  1  zero/carry registers update.
- halted  output  1  high while in HALT.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state = IDLE, instr_count = 0.
  - All outputs 0 except ir_clear = 1.
  - Release is synchronous to the next clk edge.
- Outputs are combinational from current state, opcode and zero; strobes take effect at the next rising edge.
- Every strobe not listed for a state is 0.
- States and transitions:
  - IDLE: ir_clear = 1. Stay while run = 0; go to F0 when run = 1.
  - F0: pc_out, mar_load. -> F1.
  - F1: mem_rd, ir_load, pc_inc. -> DEC.
  - DEC, by opcode:
    - 000 NOP: retire.
    - 001 LDA, 010 ADD, 011 SUB, 100 STA: ir_out, mar_load; -> E1.
    - 101 JMP: ir_out, pc_load; retire.
    - 110 JZ: ir_out, plus pc_load only if zero = 1; retire.
    - 111 HLT: retire, then -> HALT unconditionally (ignores run).
  - E1:
    - LDA: mem_rd, acc_load, alu_op = PASS, flags_load; retire.
    - ADD/SUB: mem_rd, b_load; -> E2.
    - STA: acc_out, mem_wr; retire.
  - E2: acc_load, flags_load, alu_op = ADD (010) or SUB (011); retire.
  - HALT: halted = 1, all strobes 0. Exit only via clear_n.
- Retire:
  - instr_count increments by 1 at the same edge, wrapping at 2^CNT_W - 1 -> 0.
  - Next state is F0 if run = 1, else IDLE. HLT always goes to HALT.
- opcode is latched in an internal register at the DEC edge; E1/E2 decode from the latched copy, so IR changes after DEC are ignored.
- Cycle counts per instruction (F0 through retire): NOP/JMP/JZ/HLT 3, LDA/STA 4, ADD/SUB 5.
- mem_rd and mem_wr are never high in the same cycle. pc_inc and pc_load are never high in the same cycle.
- An unencoded state value recovers to IDLE at the next edge.
- run deasserted mid-instruction has no effect until the retire point.
- clear_n asserted mid-instruction aborts immediately to IDLE and zeroes the counter.

Test Plan:
- Reset with run = 1, release clear_n -> IDLE for 1 cycle with ir_clear = 1, then F0 with pc_out = mar_load = 1; next cycle mem_rd = ir_load = pc_inc = 1.
- Opcode 010 (ADD) -> b_load in cycle 4, acc_load + alu_op = 01 + flags_load in cycle 5, instr_count 0 -> 1, F0 in cycle 6.
- Opcode 110 with zero = 0 -> pc_load = 0 in DEC. Repeat with zero = 1 -> pc_load = 1 and ir_out = 1 in DEC.
- Opcode 100 (STA) -> E1 shows acc_out = mem_wr = 1 and mem_rd = 0. Opcode 111 -> halted = 1 from the next cycle, stays through 20 cycles with run = 1, instr_count incremented once.
- Drop run during E1 of LDA -> LDA completes (count +1), then IDLE. Raise run -> F0 the next cycle.
- CNT_W = 2, run 4 NOPs -> count 1, 2, 3, 0. Assert clear_n low during E2 -> outputs go to reset values asynchronously, before the next clk edge.
